// File: rtl/apb_uart_rx_fifo_if.sv
// APB bus bundle for the UART receiver: the CPU side drives through the master modport,
// and the peripheral answers through the slave modport.
interface apb_uart_rx_fifo_if;
    logic       psel;
    logic [2:0] paddr;
    logic       penable;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pslverr;

    modport master (
        output psel, paddr, penable, pwrite, pwdata,
        input  prdata, pslverr
    );

    modport slave (
        input  psel, paddr, penable, pwrite, pwdata,
        output prdata, pslverr
    );
endinterface

// File: rtl/apb_uart_rx_fifo.sv
// APB-slave UART receiver: programmable 5..8 data bits, optional parity, an RX FIFO,
// sticky error flags cleared on read, and a level-sensitive registered interrupt.
module apb_uart_rx_fifo #(
    parameter int FIFO_DEPTH       = 8,
    parameter int RESET_BIT_PERIOD = 10,
    parameter int RESET_DATA_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    apb_uart_rx_fifo_if.slave    apb,
    output logic                 irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_e;

    logic [13:0]   bp_q;
    logic [3:0]    dsize_q;
    logic [2:0]    ctrl_q;
    logic [2:0]    sync_q;
    state_e        state_q, state_d;
    logic [13:0]   cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [13:0]   bp_lat_q, bp_lat_d;
    logic [3:0]    dsize_lat_q, dsize_lat_d;
    logic          par_en_q, par_en_d;
    logic          par_odd_q, par_odd_d;
    logic          par_bad_q, par_bad_d;
    logic          stop_bad_q, stop_bad_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [2:0]    err_q, err_d;
    logic          irq_q;

    logic          line, fall;
    logic [13:0]   bp_eff;
    logic          access, wr_acc, rd_acc, dsize_ok, slverr, commit;
    logic          empty, full, pop, push, err_clr;
    logic          set_fram, set_ovr, set_par;
    logic [7:0]    rdata;

    assign line   = sync_q[1];
    assign fall   = sync_q[2] & ~sync_q[1];
    assign bp_eff = (bp_q < 14'd4) ? 14'd4 : bp_q;

    assign access   = apb.psel & apb.penable;
    assign wr_acc   = access & apb.pwrite;
    assign rd_acc   = access & ~apb.pwrite;
    assign dsize_ok = (apb.pwdata >= 8'd5) && (apb.pwdata <= 8'd8);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = rd_acc && (apb.paddr == 3'd6) && !empty;
    assign err_clr  = rd_acc && (apb.paddr == 3'd1);
    assign commit   = wr_acc & ~slverr;

    // Bus decode: errors and read data are purely combinational so there are no wait states.
    always_comb begin
        slverr = 1'b0;
        rdata  = 8'h00;
        if (apb.paddr == 3'd7) begin
            slverr = 1'b1;
        end else if (apb.pwrite && (apb.paddr == 3'd0 || apb.paddr == 3'd1 || apb.paddr == 3'd6)) begin
            slverr = 1'b1;
        end else if (apb.pwrite && apb.paddr == 3'd4 && !dsize_ok) begin
            slverr = 1'b1;
        end
        case (apb.paddr)
            3'd0:    rdata = {4'(count_q), 2'b00, full, ~empty};
            3'd1:    rdata = {5'b0, err_q};
            3'd2:    rdata = bp_q[7:0];
            3'd3:    rdata = {2'b00, bp_q[13:8]};
            3'd4:    rdata = {4'b0, dsize_q};
            3'd5:    rdata = {5'b0, ctrl_q};
            3'd6:    rdata = empty ? 8'h00 : mem_q[rptr_q];
            default: rdata = 8'h00;
        endcase
        apb.prdata  = apb.psel ? rdata : 8'h00;
        apb.pslverr = apb.psel & slverr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_q    <= 14'(RESET_BIT_PERIOD);
            dsize_q <= 4'(RESET_DATA_SIZE);
            ctrl_q  <= 3'b100;
        end else if (commit) begin
            case (apb.paddr)
                3'd2:    bp_q[7:0]  <= apb.pwdata;
                3'd3:    bp_q[13:8] <= apb.pwdata[5:0];
                3'd4:    dsize_q    <= apb.pwdata[3:0];
                3'd5:    ctrl_q     <= apb.pwdata[2:0];
                default: ;
            endcase
        end
    end

    // Frame config is latched at the start edge so mid-frame writes only affect the next frame.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        bp_lat_d    = bp_lat_q;
        dsize_lat_d = dsize_lat_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        par_bad_d   = par_bad_q;
        stop_bad_d  = stop_bad_q;
        push        = 1'b0;
        set_fram    = 1'b0;
        set_ovr     = 1'b0;
        set_par     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_q[2] && fall) begin
                    bp_lat_d    = bp_eff;
                    dsize_lat_d = dsize_q;
                    par_en_d    = ctrl_q[0];
                    par_odd_d   = ctrl_q[1];
                    cnt_d       = bp_eff >> 1;
                    bit_idx_d   = 3'd0;
                    shift_d     = 8'h00;
                    par_bad_d   = 1'b0;
                    stop_bad_d  = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 14'd1;
                end else if (line) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = bp_lat_q - 14'd1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 14'd1;
                end else begin
                    shift_d[bit_idx_q] = line;
                    cnt_d              = bp_lat_q - 14'd1;
                    if ({1'b0, bit_idx_q} == dsize_lat_q - 4'd1) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 14'd1;
                end else begin
                    par_bad_d = ((^shift_q) ^ line) != par_odd_q;
                    cnt_d     = bp_lat_q - 14'd1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 14'd1;
                end else begin
                    stop_bad_d = ~line;
                    state_d    = PUSH;
                end
            end
            PUSH: begin
                state_d  = IDLE;
                set_fram = stop_bad_q;
                set_par  = par_bad_q;
                if (!stop_bad_q && !par_bad_q) begin
                    if (full && !pop) set_ovr = 1'b1;
                    else              push    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_clr ? 3'b000 : err_q) | {set_par, set_ovr, set_fram};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 3'b111;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            bp_lat_q    <= '0;
            dsize_lat_q <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            par_bad_q   <= 1'b0;
            stop_bad_q  <= 1'b0;
            err_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], serial_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            bp_lat_q    <= bp_lat_d;
            dsize_lat_q <= dsize_lat_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            par_bad_q   <= par_bad_d;
            stop_bad_q  <= stop_bad_d;
            err_q       <= err_d;
            irq_q       <= (|count_q) | (|err_q);
        end
    end

    // Push and pop in one cycle leave the count unchanged; pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= shift_q;
    end

    assign irq = irq_q;
endmodule
